mem_port_arbiter: RTL and testbench

// Shares the single data-memory port (address/write-data/write-enable/byte-op/incoming-data) between the instruction-fetch

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_rr2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter: FSM states, owner encoding, watchdog default.
package mem_arb_pkg;

  localparam int unsigned ARB_WIDTH_DEFAULT   = 32;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic       {OWNER_IF, OWNER_D}            arb_owner_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the side that was not granted last wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,        // bit 0 = instruction side, bit 1 = data side
  input  logic       last_grant_i, // arb_owner_t encoding
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == OWNER_D) ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: round-robin grant,
// one transaction in flight, req/ack handshake with a watchdog that returns an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = ARB_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_valid_i,
  input  logic [WIDTH-1:0] if_address_i,
  output logic             if_ready_o,
  output logic             if_rsp_valid_o,
  output logic [WIDTH-1:0] if_rdata_o,
  input  logic             d_valid_i,
  input  logic [WIDTH-1:0] d_address_i,
  input  logic             d_write_enable_i,
  input  logic             d_byte_op_i,
  input  logic [WIDTH-1:0] d_write_data_i,
  output logic             d_ready_o,
  output logic             d_rsp_valid_o,
  output logic [WIDTH-1:0] d_rdata_o,
  output logic             rsp_error_o,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_incoming_data_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TSAT  = TW'(TIMEOUT);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       last_q,  last_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             we_q,    we_d;
  logic             bop_q,   bop_d;
  logic             err_q,   err_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       grant;

  mem_arb_rr2 u_rr2 (
    .req_i        ({d_valid_i, if_valid_i}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    bop_d      = bop_q;
    err_d      = err_q;
    timer_d    = timer_q;
    if_ready_o = 1'b0;
    d_ready_o  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if_ready_o = grant[0];
        d_ready_o  = grant[1];
        if (grant[0]) begin
          owner_d = OWNER_IF;
          last_d  = OWNER_IF;
          addr_d  = if_address_i;
          wdata_d = '0;
          we_d    = 1'b0;
          bop_d   = 1'b0;
        end else if (grant[1]) begin
          owner_d = OWNER_D;
          last_d  = OWNER_D;
          addr_d  = d_address_i;
          wdata_d = d_write_data_i;
          we_d    = d_write_enable_i;
          // loads always fetch the full word
          bop_d   = d_byte_op_i & d_write_enable_i;
        end
        if (|grant) begin
          timer_d = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // an ack arriving on the last allowed cycle still beats the watchdog
        if (mem_ack_i) begin
          rdata_d = we_q ? '0 : mem_incoming_data_i;
          state_d = ARB_RESP;
        end else if (timer_q >= TLAST) begin
          timer_d = TSAT;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ARB_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IF;
      last_q  <= OWNER_D;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      bop_q   <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      bop_q   <= bop_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign mem_req_o          = (state_q == ARB_BUSY);
  assign mem_address_o      = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign mem_write_enable_o = we_q;
  assign mem_byte_op_o      = bop_q;

  assign if_rsp_valid_o = (state_q == ARB_RESP) && (owner_q == OWNER_IF);
  assign d_rsp_valid_o  = (state_q == ARB_RESP) && (owner_q == OWNER_D);
  assign if_rdata_o     = if_rsp_valid_o ? rdata_q : '0;
  assign d_rdata_o      = d_rsp_valid_o ? rdata_q : '0;
  assign rsp_error_o    = (state_q == ARB_RESP) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus timeout, stray-ack and mid-flight reset sequences.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_valid, if_ready, if_rsp;
  logic [31:0] if_addr, if_rdata;
  logic        d_valid, d_we, d_bop, d_ready, d_rsp;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        rsp_err, mem_req, mem_we, mem_bop, mem_ack;
  logic [31:0] mem_addr, mem_wd, mem_in;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .if_valid_i          (if_valid),
    .if_address_i        (if_addr),
    .if_ready_o          (if_ready),
    .if_rsp_valid_o      (if_rsp),
    .if_rdata_o          (if_rdata),
    .d_valid_i           (d_valid),
    .d_address_i         (d_addr),
    .d_write_enable_i    (d_we),
    .d_byte_op_i         (d_bop),
    .d_write_data_i      (d_wd),
    .d_ready_o           (d_ready),
    .d_rsp_valid_o       (d_rsp),
    .d_rdata_o           (d_rdata),
    .rsp_error_o         (rsp_err),
    .mem_req_o           (mem_req),
    .mem_address_o       (mem_addr),
    .mem_write_data_o    (mem_wd),
    .mem_write_enable_o  (mem_we),
    .mem_byte_op_o       (mem_bop),
    .mem_ack_i           (mem_ack),
    .mem_incoming_data_i (mem_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifv;
    logic        dv;
    logic [31:0] ifa;
    logic [31:0] da;
    logic        we;
    logic        bop;
    logic [31:0] wd;
    int          k;        // ack in the k-th BUSY cycle
    logic [31:0] mdata;
    logic        exp_d;    // 1 = data side expected to win
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_bop;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(input string tag, output logic ok);
    int n = 0;
    #1;
    while (!(if_ready | d_ready) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = if_ready | d_ready;
    if (!ok) chk1({tag, " grant wait"}, 1'b0, 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic ok;
    @(negedge clk);
    if_valid = v.ifv; if_addr = v.ifa;
    d_valid = v.dv; d_addr = v.da; d_we = v.we; d_bop = v.bop; d_wd = v.wd;
    wait_grant(tag, ok);
    if (ok) begin
      chk1({tag, " owner"}, d_ready, v.exp_d);
      chk1({tag, " one ready"}, if_ready & d_ready, 1'b0);
      @(negedge clk);
      if (v.exp_d) d_valid = 1'b0; else if_valid = 1'b0;
      #1;
      chk1({tag, " mem_req"}, mem_req, 1'b1);
      chk32({tag, " mem_addr"}, mem_addr, v.exp_addr);
      chk1({tag, " mem_we"}, mem_we, v.exp_we);
      chk1({tag, " mem_bop"}, mem_bop, v.exp_bop);
      if (v.exp_we) chk32({tag, " mem_wd"}, mem_wd, v.wd);
      chk1({tag, " busy ready"}, if_ready | d_ready, 1'b0);
      for (int c = 1; c <= v.k; c++) begin
        if (c > 1) begin
          @(negedge clk);
          #1;
          chk1({tag, " req held"}, mem_req, 1'b1);
        end
        if (c == v.k) begin
          mem_ack = 1'b1;
          mem_in  = v.mdata;
        end
      end
      chk32({tag, " addr held"}, mem_addr, v.exp_addr);
      @(negedge clk);
      mem_ack = 1'b0;
      mem_in  = 32'hBAD0BAD0;
      #1;
      chk1({tag, " rsp owner"}, v.exp_d ? d_rsp : if_rsp, 1'b1);
      chk1({tag, " rsp other"}, v.exp_d ? if_rsp : d_rsp, 1'b0);
      chk32({tag, " rdata"}, v.exp_d ? d_rdata : if_rdata, v.exp_rdata);
      chk1({tag, " err"}, rsp_err, v.exp_err);
      chk1({tag, " req dropped"}, mem_req, 1'b0);
      chk1({tag, " resp ready"}, if_ready | d_ready, 1'b0);
      @(negedge clk);
      if_valid = 1'b0; d_valid = 1'b0;
      #1;
      chk1({tag, " pulse end"}, if_rsp | d_rsp, 1'b0);
    end
  endtask

  initial begin
    logic ok;
    int   n;
    vec_t v;
    tbl[0] = '{1'b1, 1'b1, 32'h1000, 32'h100, 1'b0, 1'b0, 32'h0, 1, 32'h11111111, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h11111111, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h1000, 32'h100, 1'b0, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b1, 32'h100, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h1004, 32'h104, 1'b0, 1'b0, 32'h0, 3, 32'h22222222, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h22222222, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h1008, 32'h108, 1'b0, 1'b0, 32'h0, 1, 32'h33333333, 1'b1, 32'h108, 1'b0, 1'b0, 32'h33333333, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h203, 1'b1, 1'b1, 32'hAB, 2, 32'h55555555, 1'b1, 32'h203, 1'b1, 1'b1, 32'h0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h204, 1'b0, 1'b1, 32'h0, 1, 32'hCAFEF00D, 1'b1, 32'h204, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0, 15, 32'h12345678, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h12345678, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 32'h300, 1'b1, 1'b0, 32'h87654321, 4, 32'h44444444, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 32'h3000, 32'h304, 1'b1, 1'b1, 32'hFF, 1, 32'h66666666, 1'b0, 32'h3000, 1'b0, 1'b0, 32'h66666666, 1'b0};

    rst_n = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_bop = 1'b0; d_wd = '0;
    mem_ack = 1'b0; mem_in = '0;
    @(negedge clk);
    #1;
    chk1("reset mem_req", mem_req, 1'b0);
    chk32("reset mem_addr", mem_addr, 32'h0);
    chk1("reset rsp", if_rsp | d_rsp | rsp_err, 1'b0);
    chk1("reset ready", if_ready | d_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // stray ack while idle must not produce a response
    @(negedge clk);
    mem_ack = 1'b1; mem_in = 32'hFFFF0000;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk1("stray ack rsp", if_rsp | d_rsp, 1'b0);
      chk1("stray ack req", mem_req, 1'b0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // watchdog: no ack at all
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h400; d_we = 1'b0; d_bop = 1'b0;
    mem_in = 32'h77777777;
    wait_grant("timeout", ok);
    if (ok) begin
      chk1("timeout owner", d_ready, 1'b1);
      @(negedge clk);
      d_valid = 1'b0;
      #1;
      n = 0;
      while (mem_req && n < 40) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk32("timeout req cycles", 32'(n), 32'd15);
      chk1("timeout rsp", d_rsp, 1'b1);
      chk1("timeout err", rsp_err, 1'b1);
      chk32("timeout rdata", d_rdata, 32'h0);
      @(negedge clk);
      #1;
      chk1("timeout pulse end", d_rsp | rsp_err, 1'b0);
    end

    // reset while BUSY with the instruction side owning the port
    @(negedge clk);
    if_valid = 1'b1; if_addr = 32'h5000;
    wait_grant("midreset", ok);
    if (ok) begin
      chk1("midreset owner", if_ready, 1'b1);
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      chk1("midreset busy", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midreset req async", mem_req, 1'b0);
      repeat (2) begin
        @(negedge clk);
        #1;
        chk1("midreset no rsp", if_rsp | d_rsp, 1'b0);
      end
      rst_n = 1'b1;
    end
    v = '{1'b1, 1'b1, 32'h6000, 32'h604, 1'b0, 1'b0, 32'h0, 2, 32'h99999999, 1'b0, 32'h6000, 1'b0, 1'b0, 32'h99999999, 1'b0};
    run_txn(v, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
